leb128_ser_u32: RTL and testbench

Byte-stream serializer that sits directly downstream of the combinational u32 LEB128 packer. It captures one packed word (five 7-bit-plus-glue bytes and a length) per input handshake and emits the used bytes, least-significant group first, one per cycle on a valid/ready byte stream, marking the final byte. Words pass back-to-back without bubbles, and the block counts completed words for debug.

---
 rtl/leb128_ser_u32.sv | 100 ++++++++++
 tb/tb_leb128_ser_u32.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_ser_u32.sv
// Serializes one packed LEB128 u32 word per input handshake into a valid/ready byte stream.
// Continuation bits are regenerated from the length; words stream back-to-back with no bubbles.
module leb128_ser_u32 #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       i0,
  input  logic [7:0]       i1,
  input  logic [7:0]       i2,
  input  logic [7:0]       i3,
  input  logic [7:0]       i4,
  input  logic [2:0]       ilen,
  input  logic             ivalid,
  output logic             iready,
  output logic [7:0]       odata,
  output logic             olast,
  output logic             ovalid,
  input  logic             oready,
  output logic             busy,
  output logic [CNT_W-1:0] wcount
);

  localparam int unsigned NBYTES = 5;
  localparam int unsigned IDX_W  = 3;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  logic [6:0]       b [NBYTES];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] eidx;
  logic [6:0]       cur;
  logic             accept;
  logic             byte_hs;

  // Incoming glue bits are deliberately dropped; the continuation bit is rebuilt on output.
  logic unused_glue;
  assign unused_glue = ^{i0[7], i1[7], i2[7], i3[7], i4[7]};

  assign ovalid  = (state == EMIT);
  assign busy    = ovalid;
  assign olast   = ovalid && (idx == eidx);
  assign iready  = !ovalid || (olast && oready);
  assign accept  = ivalid && iready;
  assign byte_hs = ovalid && oready;

  // Current 7-bit group selected by the emit index.
  always_comb begin
    cur = '0;
    case (idx)
      3'd0:    cur = b[0];
      3'd1:    cur = b[1];
      3'd2:    cur = b[2];
      3'd3:    cur = b[3];
      3'd4:    cur = b[4];
      default: cur = '0;
    endcase
  end

  assign odata = ovalid ? {!olast, cur} : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      eidx   <= '0;
      wcount <= '0;
      for (int k = 0; k < int'(NBYTES); k++) begin
        b[k] <= '0;
      end
    end else begin
      if (byte_hs && olast) begin
        wcount <= wcount + CNT_W'(1);
      end
      // A load on the last-byte handshake takes priority so the stream never bubbles.
      if (accept) begin
        state <= EMIT;
        idx   <= '0;
        eidx  <= (ilen > MAX_IDX) ? MAX_IDX : ilen;
        b[0]  <= i0[6:0];
        b[1]  <= i1[6:0];
        b[2]  <= i2[6:0];
        b[3]  <= i3[6:0];
        b[4]  <= i4[6:0];
      end else if (byte_hs) begin
        if (olast) begin
          state <= IDLE;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_leb128_ser_u32.sv
// Directed bench for leb128_ser_u32: scoreboard of expected bytes popped on each output handshake.
module tb_leb128_ser_u32;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       i0, i1, i2, i3, i4;
  logic [2:0]       ilen;
  logic             ivalid;
  logic             iready;
  logic [7:0]       odata;
  logic             olast;
  logic             ovalid;
  logic             oready;
  logic             busy;
  logic [CNT_W-1:0] wcount;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q [$];

  leb128_ser_u32 #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .i0     (i0),
    .i1     (i1),
    .i2     (i2),
    .i3     (i3),
    .i4     (i4),
    .ilen   (ilen),
    .ivalid (ivalid),
    .iready (iready),
    .odata  (odata),
    .olast  (olast),
    .ovalid (ovalid),
    .oready (oready),
    .busy   (busy),
    .wcount (wcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every byte handshake must match the oldest expected {last, data}.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ovalid === 1'b1 && oready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_byte", {23'd0, olast, odata}, 32'h0);
        n_checks++;
        assert (exp_q.size() != 0)
        else begin
          n_fail++;
          $error("FAIL sb_empty observed=%0d expected=nonzero", exp_q.size());
        end
      end else begin
        check("byte", {23'd0, olast, odata}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // Drive a word and push the bytes the stream must carry for it.
  task automatic set_word(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                          input logic [7:0] a3, input logic [7:0] a4, input logic [2:0] len);
    logic [7:0] arr [5];
    int n;
    arr[0] = a0; arr[1] = a1; arr[2] = a2; arr[3] = a3; arr[4] = a4;
    i0 = a0; i1 = a1; i2 = a2; i3 = a3; i4 = a4;
    ilen = len;
    ivalid = 1'b1;
    n = (len > 3'd4) ? 5 : int'(len) + 1;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({(k == n - 1), (k != n - 1), arr[k][6:0]});
    end
  endtask

  // Returns at posedge+1 of the accepting edge; ivalid is left high.
  task automatic send_word(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                           input logic [7:0] a3, input logic [7:0] a4, input logic [2:0] len);
    bit done = 1'b0;
    set_word(a0, a1, a2, a3, a4, len);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (iready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", {31'd0, iready}, 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && ovalid === 1'b0) done = 1'b1;
    end
    if (!done) check("drain_timeout", {31'd0, ovalid}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    {i0, i1, i2, i3, i4} = '0;
    ilen = '0;
    ivalid = 1'b0;
    oready = 1'b1;
    #12;
    check("rst_ovalid", {31'd0, ovalid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_odata", {24'd0, odata}, 32'h00);
    check("rst_olast", {31'd0, olast}, 32'd0);
    check("rst_iready", {31'd0, iready}, 32'd1);
    check("rst_wcount", {28'd0, wcount}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Value 300: one-cycle latency then AC, 02.
    send_word(8'hAC, 8'h02, 8'h00, 8'h00, 8'h00, 3'd1);
    ivalid = 1'b0;
    check("v300_ovalid", {31'd0, ovalid}, 32'd1);
    check("v300_byte0", {24'd0, odata}, 32'hAC);
    check("v300_olast0", {31'd0, olast}, 32'd0);
    drain();
    check("v300_wcount", {28'd0, wcount}, 32'd1);

    // Max u32 value: five bytes.
    send_word(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 3'd4);
    ivalid = 1'b0;
    drain();
    check("max_wcount", {28'd0, wcount}, 32'd2);

    // Glue override and length clamp.
    send_word(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    ivalid = 1'b0;
    check("glue_single", {24'd0, odata}, 32'h7F);
    check("glue_single_last", {31'd0, olast}, 32'd1);
    drain();
    send_word(8'h2A, 8'h05, 8'h00, 8'h00, 8'h00, 3'd1);
    ivalid = 1'b0;
    check("glue_cont", {24'd0, odata}, 32'hAA);
    drain();
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 3'd6);
    ivalid = 1'b0;
    drain();
    check("glue_wcount", {28'd0, wcount}, 32'd5);

    // Back-to-back: three 2-byte words with ivalid held high.
    send_word(8'h81, 8'h01, 8'h00, 8'h00, 8'h00, 3'd1);
    for (int w = 1; w <= 3; w++) begin
      if (w < 3) set_word(8'(8'h80 + w), 8'(w + 16), 8'h00, 8'h00, 8'h00, 3'd1);
      else ivalid = 1'b0;
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        check("b2b_ovalid", {31'd0, ovalid}, 32'd1);
        check("b2b_iready", {31'd0, iready}, {31'd0, (j == 1)});
        @(posedge clk);
        #1;
      end
    end
    check("b2b_idle", {31'd0, ovalid}, 32'd0);
    drain();
    check("b2b_wcount", {28'd0, wcount}, 32'd8);

    // Backpressure mid-word holds the second byte.
    send_word(8'h81, 8'h82, 8'h83, 8'h84, 8'h05, 3'd4);
    ivalid = 1'b0;
    @(posedge clk);
    #1;
    oready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("bp_odata", {24'd0, odata}, 32'h82);
      check("bp_olast", {31'd0, olast}, 32'd0);
      check("bp_iready", {31'd0, iready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    oready = 1'b1;
    drain();

    // Backpressure on the last byte: iready waits for oready.
    send_word(8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    ivalid = 1'b0;
    oready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      check("bpl_olast", {31'd0, olast}, 32'd1);
      check("bpl_odata", {24'd0, odata}, 32'h11);
      check("bpl_iready", {31'd0, iready}, 32'd0);
      @(posedge clk);
      #1;
    end
    oready = 1'b1;
    @(negedge clk);
    check("bpl_iready_go", {31'd0, iready}, 32'd1);
    drain();
    check("bp_wcount", {28'd0, wcount}, 32'd10);

    // Reset after byte 1 of a 5-byte word.
    send_word(8'h91, 8'h92, 8'h93, 8'h94, 8'h05, 3'd4);
    ivalid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_rst_odata", {24'd0, odata}, 32'h93);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_ovalid", {31'd0, ovalid}, 32'd0);
    check("mid_rst_odata", {24'd0, odata}, 32'h00);
    check("mid_rst_olast", {31'd0, olast}, 32'd0);
    check("mid_rst_wcount", {28'd0, wcount}, 32'd0);
    check("mid_rst_iready", {31'd0, iready}, 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_word(8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 3'd1);
    ivalid = 1'b0;
    check("post_rst_byte0", {24'd0, odata}, 32'hD5);
    check("post_rst_olast", {31'd0, olast}, 32'd0);
    drain();
    check("post_rst_wcount", {28'd0, wcount}, 32'd1);

    // Counter wrap at 2^CNT_W.
    for (int w = 0; w < 14; w++) send_word(8'(w), 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    ivalid = 1'b0;
    drain();
    check("wrap_pre", {28'd0, wcount}, 32'd15);
    send_word(8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    ivalid = 1'b0;
    drain();
    check("wrap_zero", {28'd0, wcount}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
